// File: rtl/rom_reader.sv
// rom_reader
// ----------
// Initiator side of the ROM read interface. Fetches a block of consecutive
// bytes from the rom and streams them out one at a time over a valid/ready
// handshake. For each byte it presents the address for one cycle, then
// pulses read for exactly one cycle while holding the address. It then waits
// for the rom's valid pulse and holds the captured byte until the consumer
// takes it. If the rom never answers, the block ends early with a sticky
// timeout flag.
//
// Parameters:
//   ADDR_W   rom address width (block length is 0 .. 2**ADDR_W)
//   DATA_W   rom data width
//   TIMEOUT  WAIT cycles allowed for i_rom_valid after a read pulse (>= 3)
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                start a block fetch (sampled only while idle)
//   i_base, i_len          first address and byte count, latched on start
//   o_busy                 high from accepted start until back in idle
//   o_done                 one-cycle pulse at the end of every block
//   o_error                sticky timeout flag, cleared by the next start
//   o_rom_read             registered single-cycle read strobe to the rom
//   o_rom_address          address to the rom
//   i_rom_data, i_rom_valid  rom response
//   o_data, o_valid        fetched byte and its valid flag
//   i_ready                consumer accepts o_data when o_valid && i_ready
//   o_index                offset of o_data within the block (0-based)

module rom_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_rom_read,
  output logic [ADDR_W-1:0] o_rom_address,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic              i_rom_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_index
);

  localparam int LEN_W = ADDR_W + 1;
  // Counter only needs to reach TIMEOUT-1: the last WAIT cycle is the one
  // where the counter already holds TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    offset_r;
  logic [CNT_W-1:0]    cnt_r;

  logic                busy_r;
  logic                done_r;
  logic                error_r;
  logic                rom_read_r;
  logic [ADDR_W-1:0]   rom_address_r;
  logic [DATA_W-1:0]   data_r;
  logic                valid_r;
  logic [ADDR_W-1:0]   index_r;

  logic [LEN_W-1:0]    next_offset_s;
  logic [ADDR_W-1:0]   next_addr_s;

  // Offset is one bit wider than the address so a 256-byte block can
  // compare offset+1 against len; the address itself wraps mod 2**ADDR_W.
  assign next_offset_s = offset_r + LEN_W'(1);
  assign next_addr_s   = base_r + next_offset_s[ADDR_W-1:0];

  // Block-fetch state machine with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      base_r        <= '0;
      len_r         <= '0;
      offset_r      <= '0;
      cnt_r         <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      rom_read_r    <= 1'b0;
      rom_address_r <= '0;
      data_r        <= '0;
      valid_r       <= 1'b0;
      index_r       <= '0;
    end else begin
      // Pulse outputs default low so read can never stay high two cycles.
      done_r     <= 1'b0;
      rom_read_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            base_r   <= i_base;
            len_r    <= i_len;
            offset_r <= '0;
            error_r  <= 1'b0;
            busy_r   <= 1'b1;
            if (i_len == LEN_W'(0)) begin
              state_r <= ST_FINISH;
            end else begin
              rom_address_r <= i_base;
              state_r       <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          // Address has been stable for a full cycle; raise read next.
          rom_read_r <= 1'b1;
          state_r    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_rom_valid) begin
            data_r  <= i_rom_data;
            index_r <= offset_r[ADDR_W-1:0];
            valid_r <= 1'b1;
            state_r <= ST_HOLD;
          end else if (cnt_r == CNT_LAST) begin
            error_r <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            valid_r  <= 1'b0;
            offset_r <= next_offset_s;
            if (next_offset_s == len_r) begin
              state_r <= ST_FINISH;
            end else begin
              rom_address_r <= next_addr_s;
              state_r       <= ST_SETUP;
            end
          end
        end
        ST_FINISH: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          // Unreachable encodings recover to idle with the stream closed.
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_error       = error_r;
  assign o_rom_read    = rom_read_r;
  assign o_rom_address = rom_address_r;
  assign o_data        = data_r;
  assign o_valid       = valid_r;
  assign o_index       = index_r;

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
Initiator side of the ROM read interface: fetches a block of consecutive bytes from the rom block and streams them out over a valid/ready handshake. It generates the read pulse and address the rom needs, captures rom data when the rom's valid pulse arrives, and flags a timeout if no valid pulse arrives. It sits between the rom and consumers such as sprite/score loaders in the pong datapath.

Parameters:
ADDR_W, 8, rom address width
DATA_W, 8, rom data width
TIMEOUT, 7, cycles to wait for i_rom_valid after a read pulse before error (minimum 3)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start block fetch (sampled only in IDLE)
i_base  input  ADDR_W  first rom address, latched on accepted start
i_len  input  ADDR_W+1  number of bytes, 0..256, latched on accepted start
o_busy  output  1  high from accepted start until return to IDLE
o_done  output  1  one-cycle pulse at end of block (normal or error)
o_error  output  1  sticky timeout flag, cleared on next accepted start
o_rom_read  output  1  read strobe to rom i_read
o_rom_address  output  ADDR_W  to rom i_address
i_rom_data  input  DATA_W  from rom o_data
i_rom_valid  input  1  from rom o_valid
o_data  output  DATA_W  fetched byte
o_valid  output  1  o_data valid
i_ready  input  1  consumer accepts o_data when o_valid && i_ready
o_index  output  ADDR_W  offset of current o_data within block (0-based)

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0; internal count/offset 0.
- rom contract: rom latches the address every clock and detects a rising edge of read via a 2-stage shift; data+valid arrive 2 clocks after the read pulse's first high cycle. Read must be low for at least one sampled cycle between pulses. Address must equal the target on the read pulse's first high cycle.
- States: IDLE, SETUP, ISSUE, WAIT, HOLD, FINISH.
- IDLE: i_start=1 -> latch base/len, clear o_error, o_busy=1; if len==0 -> FINISH, else -> SETUP.
- SETUP (1 cycle): o_rom_address = base + offset (mod 2^ADDR_W, wraps 255->0); o_rom_read=0. -> ISSUE.
- ISSUE (exactly 1 cycle): o_rom_read=1, address held. -> WAIT, timeout counter cleared.
- WAIT: o_rom_read=0, address held. i_rom_valid=1 -> capture i_rom_data into o_data, o_index=offset, o_valid=1 -> HOLD. Counter reaches TIMEOUT without valid -> o_error=1 -> FINISH.
- HOLD: o_data/o_index stable while o_valid && !i_ready. On handshake: o_valid=0 next cycle; offset+1; if offset+1==len -> FINISH else -> SETUP.
- FINISH (1 cycle): o_done=1, o_busy=0 next cycle. -> IDLE.
- Minimum per-byte period with i_ready held high: 5 clocks (SETUP, ISSUE, 2 WAIT, HOLD).
- i_rom_valid outside WAIT ignored; i_start outside IDLE ignored. Start in the same cycle as FINISH is ignored (start sampled only in IDLE).
- o_rom_read is registered (glitch-free); never high in two consecutive cycles.
- Reset mid-block: immediate abort, no o_done; rom sees read low.

Test Plan:
- base=0x10, len=4, i_ready=1, rom preloaded mem[n]=n^0xA5 -> o_data B5,B4,B7,B6 with o_index 0..3, one o_done pulse, o_error=0, 5-clock spacing between o_valid.
- base=0xFE, len=4 -> o_rom_address sequence FE,FF,00,01 (wrap), data matches mem.
- len=0 start -> o_done pulse 2 cycles after start, no o_rom_read pulse, no o_valid.
- i_ready held low 10 cycles on byte 1 -> o_data/o_valid stable throughout, no new o_rom_read until handshake.
- rom model with valid suppressed on 3rd read -> o_error=1 after TIMEOUT cycles in WAIT, o_done pulse, only 2 bytes out; next start clears o_error.
- i_rst_n low during WAIT of byte 2 -> all outputs 0 immediately; fresh start afterwards fetches correctly from offset 0.
